// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, GNT_IF, GNT_D)
//   grant_e        : arbitration decision made in IDLE
//   STARVE_MAX_DEF : default fetch-starvation limit (ARB_STARVE_GUARD_EN build)
//   ctr_width()    : width needed to hold a count of 0..max
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_IF   = 2'd1,
    GRANT_D    = 2'd2
  } grant_e;

  localparam int STARVE_MAX_DEF = 4;

  function automatic int ctr_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, data port and shared downstream MMU port.
//   master : environment view (requesters drive requests, MMU drives
//            mem_r_data/mem_ready)
//   slave  : arbiter view
//
// Handshake: a requester raises *_valid with stable fields and holds it
// until its *_ready pulse. *_ready is a single-cycle completion pulse that
// qualifies *_r_data in that cycle. Downstream, mem_valid with stable
// mem_* fields is held until the MMU answers with a one-cycle mem_ready.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  // fetch port
  logic             if_valid;
  logic [WIDTH-1:0] if_addr;
  logic             if_ready;
  logic [WIDTH-1:0] if_r_data;
  // data port
  logic             d_valid;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_w_data;
  logic [3:0]       d_byte_en;
  logic             d_ready;
  logic [WIDTH-1:0] d_r_data;
  // downstream MMU port
  logic             mem_valid;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_w_data;
  logic [3:0]       mem_byte_en;
  logic [WIDTH-1:0] mem_r_data;
  logic             mem_ready;

  modport master (
    output if_valid, if_addr,
    output d_valid, d_we, d_addr, d_w_data, d_byte_en,
    output mem_r_data, mem_ready,
    input  if_ready, if_r_data, d_ready, d_r_data,
    input  mem_valid, mem_we, mem_addr, mem_w_data, mem_byte_en
  );

  modport slave (
    input  if_valid, if_addr,
    input  d_valid, d_we, d_addr, d_w_data, d_byte_en,
    input  mem_r_data, mem_ready,
    output if_ready, if_r_data, d_ready, d_r_data,
    output mem_valid, mem_we, mem_addr, mem_w_data, mem_byte_en
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
// Saturating count of data grants made while fetch was waiting.
//   clk, rst   : clock, synchronous active-high reset
//   i_inc      : a data grant is being made while if_valid=1
//   i_clr      : a fetch grant is being made
//   o_cnt      : current count (0..MAX)
//   o_at_max   : count has reached MAX; the next arbitration favours fetch
module arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter (instruction fetch, load/store data) in front of a
// single MMU port. Data has fixed priority over fetch. One transaction is
// outstanding at a time and at least one IDLE cycle separates grants.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   arb           : mem_arbiter_if.slave (fetch, data and MMU signals)
//   o_state       : debug view of the FSM state
//   o_starve_cnt  : debug view of the starvation counter (0 when not built)
//
// Build option: define ARB_STARVE_GUARD_EN to add the fetch-starvation
// guard; after STARVE_MAX consecutive data grants with fetch waiting, the
// next arbitration goes to fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CTR_W      = ctr_width(STARVE_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     arb,
  output arb_state_e       o_state,
  output logic [CTR_W-1:0] o_starve_cnt
);

  arb_state_e       r_state;
  logic             r_mem_valid;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_w_data;
  logic [3:0]       r_byte_en;

  grant_e           w_grant;
  logic             w_force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic w_starve_inc;
  logic w_starve_clr;

  assign w_starve_inc = (w_grant == GRANT_D) && arb.if_valid;
  assign w_starve_clr = (w_grant == GRANT_IF);

  arb_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (CTR_W)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_cnt    (o_starve_cnt),
    .o_at_max (w_force_if)
  );
`else
  assign w_force_if   = 1'b0;
  assign o_starve_cnt = '0;
`endif

  // Arbitration is only evaluated in IDLE, which is what enforces the
  // mandatory idle cycle between transactions. A starved fetch overrides
  // data only if fetch is actually requesting.
  always_comb begin
    w_grant = GRANT_NONE;
    if (r_state == IDLE) begin
      if (arb.d_valid && !(w_force_if && arb.if_valid)) begin
        w_grant = GRANT_D;
      end else if (arb.if_valid) begin
        w_grant = GRANT_IF;
      end
    end
  end

  // Request fields are captured at grant so a requester dropping valid
  // (or changing fields) mid-transaction cannot disturb the MMU port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_w_data    <= '0;
      r_byte_en   <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          case (w_grant)
            GRANT_IF: begin
              r_state     <= GNT_IF;
              r_mem_valid <= 1'b1;
              r_we        <= 1'b0;
              r_addr      <= arb.if_addr;
              r_w_data    <= '0;
              r_byte_en   <= 4'b0000;
            end
            GRANT_D: begin
              r_state     <= GNT_D;
              r_mem_valid <= 1'b1;
              r_we        <= arb.d_we;
              r_addr      <= arb.d_addr;
              r_w_data    <= arb.d_w_data;
              r_byte_en   <= arb.d_we ? arb.d_byte_en : 4'b0000;
            end
            default: ;
          endcase
        end
        GNT_IF, GNT_D: begin
          if (arb.mem_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign arb.mem_valid   = r_mem_valid;
  assign arb.mem_we      = r_we;
  assign arb.mem_addr    = r_addr;
  assign arb.mem_w_data  = r_w_data;
  assign arb.mem_byte_en = r_byte_en;

  // Completion pulses follow mem_ready combinationally; mem_ready seen in
  // IDLE matches neither grant state and is ignored. rst gates the pulse so
  // an abandoned transaction never reports completion.
  assign arb.if_ready  = (r_state == GNT_IF) && arb.mem_ready && !rst;
  assign arb.d_ready   = (r_state == GNT_D)  && arb.mem_ready && !rst;
  assign arb.if_r_data = arb.mem_r_data;
  assign arb.d_r_data  = arb.mem_r_data;

  assign o_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Inputs are driven and outputs sampled at
// the falling clock edge (plus #1 for combinational ready paths).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W        = 32;
  localparam int SMAX     = 4;
  localparam int CW       = ctr_width(SMAX);
  localparam logic [31:0] IF_ADDR = 32'h0000_0040;
  localparam logic [31:0] D_ADDR  = 32'h0000_1004;

  logic          clk;
  logic          rst;
  arb_state_e    dbg_state;
  logic [CW-1:0] dbg_starve;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  mem_arbiter_if #(.WIDTH(W)) arb_bus ();

  mem_arbiter #(
    .WIDTH      (W),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arb          (arb_bus.slave),
    .o_state      (dbg_state),
    .o_starve_cnt (dbg_starve)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    arb_bus.if_valid   = 1'b0;
    arb_bus.if_addr    = '0;
    arb_bus.d_valid    = 1'b0;
    arb_bus.d_we       = 1'b0;
    arb_bus.d_addr     = '0;
    arb_bus.d_w_data   = '0;
    arb_bus.d_byte_en  = 4'b0000;
    arb_bus.mem_ready  = 1'b0;
    arb_bus.mem_r_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a grant, then answers it after lat cycles. Checks the
  // downstream fields every grant cycle, the single ready pulse, and the
  // following IDLE cycle. drop=1 removes valid (and scrambles the request
  // fields) in the first grant cycle.
  task automatic run_txn(input int lat, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic e_we,
                         input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic e_if, input logic drop);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!arb_bus.mem_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("grant_seen", 32'(arb_bus.mem_valid), 32'd1);
    if (!arb_bus.mem_valid) return;
    check("grant_state", 32'(dbg_state), e_if ? 32'(GNT_IF) : 32'(GNT_D));
    if (drop) begin
      if (e_if) begin
        arb_bus.if_valid = 1'b0;
        arb_bus.if_addr  = 32'hDEAD_BEEF;
      end else begin
        arb_bus.d_valid   = 1'b0;
        arb_bus.d_addr    = 32'hDEAD_BEEF;
        arb_bus.d_w_data  = 32'h5555_5555;
        arb_bus.d_byte_en = 4'b1111;
        arb_bus.d_we      = ~arb_bus.d_we;
      end
    end
    for (int k = 0; k < lat; k++) begin
      if (k == lat - 1) begin
        arb_bus.mem_ready  = 1'b1;
        arb_bus.mem_r_data = rdata;
      end
      #1;
      check("mem_valid", 32'(arb_bus.mem_valid), 32'd1);
      check("mem_addr", arb_bus.mem_addr, e_addr);
      check("mem_we", 32'(arb_bus.mem_we), 32'(e_we));
      check("mem_byte_en", 32'(arb_bus.mem_byte_en), 32'(e_be));
      check("mem_w_data", arb_bus.mem_w_data, e_wdata);
      if (k == lat - 1) begin
        check("if_ready_pulse", 32'(arb_bus.if_ready), 32'(e_if));
        check("d_ready_pulse", 32'(arb_bus.d_ready), 32'(!e_if));
        check(e_if ? "if_r_data" : "d_r_data",
              e_if ? arb_bus.if_r_data : arb_bus.d_r_data, rdata);
      end else begin
        check("if_ready_wait", 32'(arb_bus.if_ready), 32'd0);
        check("d_ready_wait", 32'(arb_bus.d_ready), 32'd0);
      end
      @(negedge clk);
    end
    arb_bus.mem_ready = 1'b0;
    if (e_if) arb_bus.if_valid = 1'b0;
    else      arb_bus.d_valid  = 1'b0;
    #1;
    check("post_state_idle", 32'(dbg_state), 32'(IDLE));
    check("post_mem_valid", 32'(arb_bus.mem_valid), 32'd0);
    check("post_if_ready", 32'(arb_bus.if_ready), 32'd0);
    check("post_d_ready", 32'(arb_bus.d_ready), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    logic [31:0] exp_addr;
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // reset state
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mem_valid", 32'(arb_bus.mem_valid), 32'd0);
    check("rst_mem_we", 32'(arb_bus.mem_we), 32'd0);
    check("rst_mem_addr", arb_bus.mem_addr, 32'd0);
    check("rst_mem_w_data", arb_bus.mem_w_data, 32'd0);
    check("rst_mem_byte_en", 32'(arb_bus.mem_byte_en), 32'd0);
    check("rst_starve_cnt", 32'(dbg_starve), 32'd0);

    // fetch alone, MMU answers on the third grant cycle
    arb_bus.if_valid = 1'b1;
    arb_bus.if_addr  = IF_ADDR;
    run_txn(3, 32'h0000_0013, IF_ADDR, 1'b0, 4'b0000, 32'd0, 1'b1, 1'b0);

    // both valid: data store first, fetch after an IDLE cycle
    @(negedge clk);
    arb_bus.if_valid  = 1'b1;
    arb_bus.if_addr   = IF_ADDR;
    arb_bus.d_valid   = 1'b1;
    arb_bus.d_we      = 1'b1;
    arb_bus.d_addr    = D_ADDR;
    arb_bus.d_w_data  = 32'h00AA_0000;
    arb_bus.d_byte_en = 4'b0100;
    run_txn(2, 32'h1111_2222, D_ADDR, 1'b1, 4'b0100, 32'h00AA_0000, 1'b0, 1'b0);
    check("both_if_still_valid", 32'(arb_bus.if_valid), 32'd1);
    run_txn(1, 32'h3333_4444, IF_ADDR, 1'b0, 4'b0000, 32'd0, 1'b1, 1'b0);

    // data load drops valid after grant; latched copy completes
    @(negedge clk);
    arb_bus.d_valid   = 1'b1;
    arb_bus.d_we      = 1'b0;
    arb_bus.d_addr    = D_ADDR;
    arb_bus.d_w_data  = 32'h0000_0000;
    arb_bus.d_byte_en = 4'b0011;
    run_txn(3, 32'hCAFE_F00D, D_ADDR, 1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);

    // reset during GNT_D abandons the transaction
    @(negedge clk);
    arb_bus.d_valid   = 1'b1;
    arb_bus.d_we      = 1'b1;
    arb_bus.d_addr    = D_ADDR;
    arb_bus.d_w_data  = 32'h00AA_0000;
    arb_bus.d_byte_en = 4'b0100;
    @(negedge clk);
    #1;
    check("rstg_state", 32'(dbg_state), 32'(GNT_D));
    @(negedge clk);
    rst               = 1'b1;
    arb_bus.d_valid   = 1'b0;
    arb_bus.mem_ready = 1'b1;
    #1;
    check("rstg_d_ready_in_rst", 32'(arb_bus.d_ready), 32'd0);
    check("rstg_if_ready_in_rst", 32'(arb_bus.if_ready), 32'd0);
    @(negedge clk);
    rst               = 1'b0;
    arb_bus.mem_ready = 1'b0;
    #1;
    check("rstg_mem_valid", 32'(arb_bus.mem_valid), 32'd0);
    check("rstg_mem_addr", arb_bus.mem_addr, 32'd0);
    check("rstg_mem_byte_en", 32'(arb_bus.mem_byte_en), 32'd0);
    check("rstg_state_idle", 32'(dbg_state), 32'(IDLE));
    check("rstg_d_ready", 32'(arb_bus.d_ready), 32'd0);

    // stray mem_ready in IDLE
    @(negedge clk);
    arb_bus.mem_ready  = 1'b1;
    arb_bus.mem_r_data = 32'h7777_7777;
    #1;
    check("stray_if_ready", 32'(arb_bus.if_ready), 32'd0);
    check("stray_d_ready", 32'(arb_bus.d_ready), 32'd0);
    @(negedge clk);
    arb_bus.mem_ready = 1'b0;
    #1;
    check("stray_state", 32'(dbg_state), 32'(IDLE));
    check("stray_mem_valid", 32'(arb_bus.mem_valid), 32'd0);

    // both valid continuously: grant order scoreboard
    do_reset();
    for (int g = 0; g < 10; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_q.push_back((g % 5 == 4) ? IF_ADDR : D_ADDR);
`else
      exp_q.push_back(D_ADDR);
`endif
    end
    arb_bus.if_valid  = 1'b1;
    arb_bus.if_addr   = IF_ADDR;
    arb_bus.d_valid   = 1'b1;
    arb_bus.d_we      = 1'b0;
    arb_bus.d_addr    = D_ADDR;
    arb_bus.d_byte_en = 4'b0000;
    while (exp_q.size() > 0) begin
      waited = 0;
      @(negedge clk);
      while (!arb_bus.mem_valid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check("order_grant_seen", 32'(arb_bus.mem_valid), 32'd1);
      if (!arb_bus.mem_valid) break;
      exp_addr = exp_q.pop_front();
      check("order_grant_addr", arb_bus.mem_addr, exp_addr);
      arb_bus.mem_ready = 1'b1;
      #1;
      check("order_if_ready", 32'(arb_bus.if_ready), 32'(exp_addr == IF_ADDR));
      check("order_d_ready", 32'(arb_bus.d_ready), 32'(exp_addr == D_ADDR));
      @(negedge clk);
      arb_bus.mem_ready = 1'b0;
    end
    check("order_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
